// File: rtl/l2_l1_msg_queue_if.sv
// Request and delivery channels between the LLC controller, the message queue and the L1 side.
interface l2_l1_msg_queue_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              msg_valid;
    logic              msg_ready;
    logic [2:0]        msg_type;
    logic [ADDR_W-1:0] msg_addr;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_type;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output msg_valid, msg_type, msg_addr, out_ready,
        input  msg_ready, out_valid, out_type, out_addr
    );

    modport slave (
        input  msg_valid, msg_type, msg_addr, out_ready,
        output msg_ready, out_valid, out_type, out_addr
    );
endinterface

// File: rtl/l2_l1_msg_queue.sv
// L2-to-L1 cache message FIFO with silent mode and saturating per-type/suppressed/invalid statistics.
module l2_l1_msg_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 normal_mode,
    l2_l1_msg_queue_if.slave     q,
    output logic [LVL_W-1:0]     level,
    output logic [4*CNT_W-1:0]   cnt_msg,
    output logic [CNT_W-1:0]     cnt_suppressed,
    output logic [CNT_W-1:0]     cnt_invalid,
    output logic                 err_invalid
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [2:0]        r_mem_type [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [CNT_W-1:0]  r_cnt_msg [4];
    logic [CNT_W-1:0]  r_cnt_sup;
    logic [CNT_W-1:0]  r_cnt_inv;
    logic              r_err;

    logic w_full;
    logic w_accept;
    logic w_type_ok;
    logic w_push;
    logic w_pop;
    logic w_out_valid;

    assign w_full      = (r_level == LVL_W'(DEPTH));
    assign w_out_valid = (r_level != '0);
    assign w_type_ok   = (q.msg_type >= 3'd1) && (q.msg_type <= 3'd4);
    assign w_accept    = q.msg_valid && q.msg_ready;
    assign w_push      = w_accept && w_type_ok && normal_mode;
    assign w_pop       = w_out_valid && q.out_ready;

    // Ready is independent of out_ready: a full queue never bypasses to the L1 side.
    assign q.msg_ready = !w_full && !rst;
    assign q.out_valid = w_out_valid;
    assign q.out_type  = w_out_valid ? r_mem_type[r_rd_ptr] : 3'd0;
    assign q.out_addr  = w_out_valid ? r_mem_addr[r_rd_ptr] : '0;

    assign level          = r_level;
    assign cnt_suppressed = r_cnt_sup;
    assign cnt_invalid    = r_cnt_inv;
    assign err_invalid    = r_err;

    always_comb begin
        cnt_msg = '0;
        for (int k = 0; k < 4; k++) begin
            cnt_msg[k*CNT_W +: CNT_W] = r_cnt_msg[k];
        end
    end

    // Payload storage needs no reset; out_* are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_type[r_wr_ptr] <= q.msg_type;
            r_mem_addr[r_wr_ptr] <= q.msg_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Statistics: classification priority is invalid, then suppressed, then enqueued.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt_msg[k] <= '0;
            end
            r_cnt_sup <= '0;
            r_cnt_inv <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && !w_type_ok;
            if (w_accept && !w_type_ok) begin
                if (r_cnt_inv != '1) begin
                    r_cnt_inv <= r_cnt_inv + CNT_W'(1);
                end
            end else if (w_accept && !normal_mode) begin
                if (r_cnt_sup != '1) begin
                    r_cnt_sup <= r_cnt_sup + CNT_W'(1);
                end
            end else if (w_push) begin
                for (int k = 0; k < 4; k++) begin
                    if ((q.msg_type == 3'(k + 1)) && (r_cnt_msg[k] != '1)) begin
                        r_cnt_msg[k] <= r_cnt_msg[k] + CNT_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_l2_l1_msg_queue.sv
// Self-checking bench: directed vector table plus a FIFO scoreboard and counter model.
module tb_l2_l1_msg_queue;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int unsigned SAT    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [2:0]        t;
        logic [ADDR_W-1:0] a;
    } ent_t;

    typedef struct {
        logic        v;
        logic [2:0]  t;
        logic [31:0] a;
        logic        nm;
        logic        ordy;
        int          exp_level;
        logic        exp_err;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                normal_mode = 1'b1;
    logic [LVL_W-1:0]    level;
    logic [4*CNT_W-1:0]  cnt_msg;
    logic [CNT_W-1:0]    cnt_suppressed;
    logic [CNT_W-1:0]    cnt_invalid;
    logic                err_invalid;

    l2_l1_msg_queue_if #(.ADDR_W(ADDR_W)) bus ();

    l2_l1_msg_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .normal_mode    (normal_mode),
        .q              (bus.slave),
        .level          (level),
        .cnt_msg        (cnt_msg),
        .cnt_suppressed (cnt_suppressed),
        .cnt_invalid    (cnt_invalid),
        .err_invalid    (err_invalid)
    );

    always #5 clk = ~clk;

    ent_t        sb[$];
    int unsigned m_cnt[4];
    int unsigned m_sup;
    int unsigned m_inv;
    logic        m_err;
    int          n_cmp;
    int          n_fail;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned x);
        return (x >= SAT) ? x : x + 1;
    endfunction

    task automatic clear_model();
        sb.delete();
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        m_sup = 0;
        m_inv = 0;
        m_err = 1'b0;
    endtask

    task automatic chk_counters();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cnt_msg[%0d]", k), 64'(cnt_msg[k*CNT_W +: CNT_W]), 64'(m_cnt[k]));
        end
        chk("cnt_suppressed", 64'(cnt_suppressed), 64'(m_sup));
        chk("cnt_invalid", 64'(cnt_invalid), 64'(m_inv));
        chk("err_invalid", 64'(err_invalid), 64'(m_err));
    endtask

    // One clock of stimulus: checks pre-edge outputs, updates the model, checks post-edge stats.
    task automatic step(input logic v, input logic [2:0] t, input logic [31:0] a, input logic ordy);
        int   sz;
        logic acc;
        logic tok;
        ent_t e;
        bus.msg_valid = v;
        bus.msg_type  = t;
        bus.msg_addr  = a;
        bus.out_ready = ordy;
        #1;
        sz = sb.size();
        chk("msg_ready", 64'(bus.msg_ready), 64'(sz < int'(DEPTH)));
        chk("out_valid", 64'(bus.out_valid), 64'(sz != 0));
        chk("level", 64'(level), 64'(sz));
        if (sz != 0) begin
            chk("out_type", 64'(bus.out_type), 64'(sb[0].t));
            chk("out_addr", 64'(bus.out_addr), 64'(sb[0].a));
        end else begin
            chk("out_type_idle", 64'(bus.out_type), 64'd0);
            chk("out_addr_idle", 64'(bus.out_addr), 64'd0);
        end
        acc = v && (sz < int'(DEPTH));
        tok = (t >= 3'd1) && (t <= 3'd4);
        if (sz != 0 && ordy) e = sb.pop_front();
        if (acc && !tok) m_inv = sat_inc(m_inv);
        else if (acc && !normal_mode) m_sup = sat_inc(m_sup);
        else if (acc) begin
            sb.push_back('{t: t, a: a});
            m_cnt[int'(t) - 1] = sat_inc(m_cnt[int'(t) - 1]);
        end
        m_err = acc && !tok;
        @(posedge clk);
        @(negedge clk);
        chk_counters();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.msg_valid = 1'b0;
        bus.msg_type  = 3'd0;
        bus.msg_addr  = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
        chk("rst_msg_ready", 64'(bus.msg_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_type", 64'(bus.out_type), 64'd0);
        chk("rst_out_addr", 64'(bus.out_addr), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk_counters();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(bus.msg_ready), 64'd1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear_model();
        vecs[0] = '{1'b1, 3'd1, 32'h0000_1000, 1'b1, 1'b1, 1, 1'b0};
        vecs[1] = '{1'b0, 3'd0, 32'h0000_0000, 1'b1, 1'b1, 0, 1'b0};
        vecs[2] = '{1'b1, 3'd0, 32'h0000_0bad, 1'b1, 1'b1, 0, 1'b1};
        vecs[3] = '{1'b1, 3'd7, 32'h0000_0bad, 1'b1, 1'b1, 0, 1'b1};
        vecs[4] = '{1'b0, 3'd0, 32'h0000_0000, 1'b1, 1'b1, 0, 1'b0};
        vecs[5] = '{1'b1, 3'd2, 32'h0000_2000, 1'b1, 1'b0, 1, 1'b0};
        vecs[6] = '{1'b1, 3'd3, 32'h0000_3000, 1'b1, 1'b1, 1, 1'b0};
        vecs[7] = '{1'b0, 3'd0, 32'h0000_0000, 1'b1, 1'b1, 0, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            normal_mode = vecs[i].nm;
            step(vecs[i].v, vecs[i].t, vecs[i].a, vecs[i].ordy);
            chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
            chk($sformatf("vec%0d_err", i), 64'(err_invalid), 64'(vecs[i].exp_err));
        end
        chk("invalid_total", 64'(cnt_invalid), 64'd2);

        // Fill to DEPTH, reject a ninth push, then drain in order.
        do_reset();
        normal_mode = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 3'((i % 4) + 1), 32'h100 + 32'(i * 16), 1'b0);
        chk("full_level", 64'(level), 64'(DEPTH));
        step(1'b1, 3'd1, 32'hdead_beef, 1'b0);
        chk("full_level_after_9th", 64'(level), 64'(DEPTH));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 32'd0, 1'b1);
            if (i == 0) chk("ready_after_first_pop", 64'(bus.msg_ready), 64'd1);
        end
        chk("drained_level", 64'(level), 64'd0);

        // Silent mode discards new requests; queued entries still drain.
        do_reset();
        normal_mode = 1'b1;
        step(1'b1, 3'd2, 32'h0000_a000, 1'b0);
        step(1'b1, 3'd3, 32'h0000_a040, 1'b0);
        normal_mode = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 3'd4, 32'h0000_b000 + 32'(i), 1'b0);
        chk("suppressed_3", 64'(cnt_suppressed), 64'd3);
        chk("silent_level", 64'(level), 64'd2);
        step(1'b0, 3'd0, 32'd0, 1'b1);
        normal_mode = 1'b1;
        step(1'b0, 3'd0, 32'd0, 1'b1);
        step(1'b0, 3'd0, 32'd0, 1'b1);

        // Steady state at level 4 with simultaneous push and pop; pointers wrap.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i + 1), 32'h4000 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 3'($urandom_range(4, 1)), $urandom, 1'b1);
            chk("steady_level", 64'(level), 64'd4);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 32'd0, 1'b1);

        // Counter saturation, then reset with entries queued.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 3'd1, 32'h8000 + 32'(i), 1'b1);
        chk("sat_cnt_msg0", 64'(cnt_msg[0 +: CNT_W]), 64'(SAT));
        step(1'b0, 3'd0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 32'h9000 + 32'(i), 1'b0);
        chk("pre_reset_level", 64'(level), 64'd3);
        do_reset();
        step(1'b0, 3'd0, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
